// File: rtl/atari_slapstik_gen_pkg.sv
// Shared state encodings, pattern indices and default decode constants for the slapstik bank generator.
// Purely declarative; no logic, no latency, no backpressure.
package slapstik_pkg;

    typedef enum logic [3:0] {
        ST_DIS  = 4'd0,
        ST_EN   = 4'd1,
        ST_ALT1 = 4'd2,
        ST_ALT2 = 4'd3,
        ST_ALT3 = 4'd4,
        ST_BIT1 = 4'd5,
        ST_BIT2 = 4'd6,
        ST_BIT3 = 4'd7,
        ST_ADD1 = 4'd8,
        ST_ADD2 = 4'd9,
        ST_ADD3 = 4'd10
    } state_e;

    // Index of each address pattern in the matcher hit vector
    localparam int P_ALT1 = 0;
    localparam int P_ALT2 = 1;
    localparam int P_ALT3 = 2;
    localparam int P_ALT4 = 3;
    localparam int P_BIT1 = 4;
    localparam int P_BIT2 = 5;
    localparam int P_BIT3 = 6;
    localparam int P_ADD1 = 7;
    localparam int P_ADDI = 8;
    localparam int P_ADDD = 9;
    localparam int P_ADD3 = 10;
    localparam int NPAT   = 11;

    localparam int DEF_ABITS      = 13;
    localparam int DEF_BANKS      = 4;
    localparam int DEF_RESET_ADDR = 'h0000;
    localparam int DEF_BANK_BASE  = 'h0080;
    localparam int DEF_BANK_SHIFT = 4;

    // ALT1 value lies outside its mask, so it can never match
    localparam int DEF_ALT1_MASK = 'h007F, DEF_ALT1_VAL = 'h1FFF;
    localparam int DEF_ALT2_MASK = 'h1FFF, DEF_ALT2_VAL = 'h1DFF;
    localparam int DEF_ALT3_MASK = 'h1FFC, DEF_ALT3_VAL = 'h1B5C;
    localparam int DEF_ALT4_MASK = 'h1FCF, DEF_ALT4_VAL = 'h0080;
    localparam int DEF_BIT1_MASK = 'h1FF0, DEF_BIT1_VAL = 'h1540;
    localparam int DEF_BIT2_MASK = 'h1FF0, DEF_BIT2_VAL = 'h1540;
    localparam int DEF_BIT3_MASK = 'h1FF8, DEF_BIT3_VAL = 'h1550;
    localparam int DEF_ADD_MASK  = 'h0000, DEF_ADD_VAL  = 'h0000;

    function automatic int bank_addr(input int base, input int shift, input int k);
        return base + (k << shift);
    endfunction

endpackage

// File: rtl/atari_slapstik_gen_if.sv
// Access bus into the slapstik: CS/AD in, registered bank select and debug state out.
// No handshake; one access per CS cycle, never backpressured.
interface atari_slapstik_gen_if #(
    parameter int ABITS = 13,
    parameter int BSW   = 2
);
    logic             CS;
    logic [ABITS-1:0] AD;
    logic [BSW-1:0]   BS;
    logic             BS_CHG;
    logic [3:0]       ST;

    modport master (output CS, AD, input BS, BS_CHG, ST);
    modport slave  (input CS, AD, output BS, BS_CHG, ST);
endinterface

// File: rtl/atari_slapstik_gen_match.sv
// Combinational masked address compare: hit when (addr & MASK) == VALUE.
// Zero latency, no backpressure.
module slapstik_match #(
    parameter int ABITS = 13,
    parameter int MASK  = 0,
    parameter int VALUE = 0
) (
    input  logic [ABITS-1:0] addr,
    output logic             hit
);
    localparam logic [ABITS-1:0] M = ABITS'(MASK);
    localparam logic [ABITS-1:0] V = ABITS'(VALUE);

    assign hit = (addr & M) == V;
endmodule

// File: rtl/atari_slapstik_gen.sv
// Slapstik-style bank switch: address-sequence FSM selecting a ROM bank; outputs registered, 1-cycle latency.
// Never backpressures; cycles with CS low are ignored.
module atari_slapstik_gen
    import slapstik_pkg::*;
#(
    parameter int ABITS      = DEF_ABITS,
    parameter int BANKS      = DEF_BANKS,
    parameter int INIT_BANK  = BANKS - 1,
    parameter int RESET_ADDR = DEF_RESET_ADDR,
    parameter int BANK_BASE  = DEF_BANK_BASE,
    parameter int BANK_SHIFT = DEF_BANK_SHIFT,
    parameter int ALT1_MASK  = DEF_ALT1_MASK, parameter int ALT1_VAL = DEF_ALT1_VAL,
    parameter int ALT2_MASK  = DEF_ALT2_MASK, parameter int ALT2_VAL = DEF_ALT2_VAL,
    parameter int ALT3_MASK  = DEF_ALT3_MASK, parameter int ALT3_VAL = DEF_ALT3_VAL,
    parameter int ALT4_MASK  = DEF_ALT4_MASK, parameter int ALT4_VAL = DEF_ALT4_VAL,
    parameter int BIT1_MASK  = DEF_BIT1_MASK, parameter int BIT1_VAL = DEF_BIT1_VAL,
    parameter int BIT2_MASK  = DEF_BIT2_MASK, parameter int BIT2_VAL = DEF_BIT2_VAL,
    parameter int BIT3_MASK  = DEF_BIT3_MASK, parameter int BIT3_VAL = DEF_BIT3_VAL,
    parameter int ADD1_MASK  = DEF_ADD_MASK,  parameter int ADD1_VAL = DEF_ADD_VAL,
    parameter int ADDI_MASK  = DEF_ADD_MASK,  parameter int ADDI_VAL = DEF_ADD_VAL,
    parameter int ADDD_MASK  = DEF_ADD_MASK,  parameter int ADDD_VAL = DEF_ADD_VAL,
    parameter int ADD3_MASK  = DEF_ADD_MASK,  parameter int ADD3_VAL = DEF_ADD_VAL,
    parameter int EN_ALT     = 1,
    parameter int EN_BIT     = 1,
    parameter int EN_ADD     = 0
) (
    input  logic                CLK,
    input  logic                RST_N,
    atari_slapstik_gen_if.slave bus
);
    localparam int BSW = $clog2(BANKS);

    localparam int PAT_MASK [NPAT] = '{ALT1_MASK, ALT2_MASK, ALT3_MASK, ALT4_MASK,
                                       BIT1_MASK, BIT2_MASK, BIT3_MASK,
                                       ADD1_MASK, ADDI_MASK, ADDD_MASK, ADD3_MASK};
    localparam int PAT_VAL  [NPAT] = '{ALT1_VAL, ALT2_VAL, ALT3_VAL, ALT4_VAL,
                                       BIT1_VAL, BIT2_VAL, BIT3_VAL,
                                       ADD1_VAL, ADDI_VAL, ADDD_VAL, ADD3_VAL};

    state_e           state_q, state_d;
    logic [BSW-1:0]   bs_q, bs_d;
    logic [BSW-1:0]   ta_q, ta_d;
    logic [BSW-1:0]   tb_q, tb_d;
    logic             tog_q, tog_d;
    logic             bs_chg_q, bs_chg_d;

    logic [ABITS-1:0] ad;
    logic [ABITS-1:0] ad_tog;
    logic [NPAT-1:0]  hit;
    logic             is_bank;
    logic [BSW-1:0]   bank_idx;

    assign ad     = bus.AD;
    // BIT2 sees the address with its low two bits flipped while tog is set
    assign ad_tog = ad ^ ABITS'({tog_q, tog_q});

    for (genvar i = 0; i < NPAT; i++) begin : g_pat
        slapstik_match #(
            .ABITS (ABITS),
            .MASK  (PAT_MASK[i]),
            .VALUE (PAT_VAL[i])
        ) u_match (
            .addr ((i == P_BIT2) ? ad_tog : ad),
            .hit  (hit[i])
        );
    end

    always_comb begin
        is_bank  = 1'b0;
        bank_idx = '0;
        for (int k = 0; k < BANKS; k++) begin
            if (ad == ABITS'(bank_addr(BANK_BASE, BANK_SHIFT, k))) begin
                is_bank  = 1'b1;
                bank_idx = BSW'(k);
            end
        end
    end

    always_comb begin
        state_d  = state_q;
        bs_d     = bs_q;
        ta_d     = ta_q;
        tb_d     = tb_q;
        tog_d    = tog_q;
        bs_chg_d = 1'b0;
        if (bus.CS) begin
            if (ad == ABITS'(RESET_ADDR)) begin
                state_d = ST_EN;
            end else begin
                case (state_q)
                    ST_EN: begin
                        if (is_bank) begin
                            bs_d     = bank_idx;
                            bs_chg_d = 1'b1;
                            state_d  = ST_DIS;
                        end else if ((EN_ALT != 0) && hit[P_ALT1]) state_d = ST_ALT1;
                        else if ((EN_ALT != 0) && hit[P_ALT2])     state_d = ST_ALT2;
                        else if ((EN_BIT != 0) && hit[P_BIT1])     state_d = ST_BIT1;
                        else if ((EN_ADD != 0) && hit[P_ADD1])     state_d = ST_ADD1;
                    end
                    ST_ALT1: state_d = hit[P_ALT2] ? ST_ALT2 : ST_EN;
                    ST_ALT2: begin
                        if (hit[P_ALT3]) begin
                            ta_d    = ad[BSW-1:0];
                            state_d = ST_ALT3;
                        end else begin
                            state_d = ST_EN;
                        end
                    end
                    ST_ALT3: begin
                        if (hit[P_ALT4]) begin
                            bs_d     = ta_q;
                            bs_chg_d = 1'b1;
                            state_d  = ST_DIS;
                        end
                    end
                    ST_BIT1: begin
                        if (is_bank) begin
                            tb_d    = bs_q;
                            tog_d   = 1'b0;
                            state_d = ST_BIT2;
                        end
                    end
                    ST_BIT2: begin
                        // Bit indices at or beyond BSW still toggle but write nothing
                        if (hit[P_BIT2]) begin
                            for (int i = 0; i < BSW; i++) begin
                                if (int'(ad_tog[BSW:1]) == i) tb_d[i] = ad_tog[0];
                            end
                            tog_d = ~tog_q;
                        end else if (hit[P_BIT3]) begin
                            state_d = ST_BIT3;
                        end
                    end
                    ST_BIT3: begin
                        if (is_bank) begin
                            bs_d     = tb_q;
                            bs_chg_d = 1'b1;
                            state_d  = ST_DIS;
                        end
                    end
                    ST_ADD1: begin
                        if (is_bank) begin
                            ta_d    = bs_q;
                            state_d = ST_ADD2;
                        end
                    end
                    ST_ADD2: begin
                        if (hit[P_ADDI])      ta_d    = ta_q + BSW'(1);
                        else if (hit[P_ADDD]) ta_d    = ta_q - BSW'(1);
                        else if (hit[P_ADD3]) state_d = ST_ADD3;
                    end
                    ST_ADD3: begin
                        if (is_bank) begin
                            bs_d     = ta_q;
                            bs_chg_d = 1'b1;
                            state_d  = ST_DIS;
                        end
                    end
                    ST_DIS:  state_d = ST_DIS;
                    default: state_d = ST_DIS;
                endcase
            end
        end
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q  <= ST_DIS;
            bs_q     <= BSW'(INIT_BANK);
            ta_q     <= '0;
            tb_q     <= '0;
            tog_q    <= 1'b0;
            bs_chg_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            bs_q     <= bs_d;
            ta_q     <= ta_d;
            tb_q     <= tb_d;
            tog_q    <= tog_d;
            bs_chg_q <= bs_chg_d;
        end
    end

    assign bus.BS     = bs_q;
    assign bus.BS_CHG = bs_chg_q;
    assign bus.ST     = state_q;

endmodule

// File: tb/tb_atari_slapstik_gen.sv
// Bench for atari_slapstik_gen: default-config and 8-bank/ADD-enabled instances, checked against
// an arithmetic reference model through a per-instance expected-response queue.
module tb_atari_slapstik_gen;

    typedef struct {
        int bs;
        int chg;
        int st;
    } exp_t;

    logic clk   = 1'b0;
    logic rst_n = 1'b1;
    always #5 clk = ~clk;

    atari_slapstik_gen_if #(.ABITS(13), .BSW(2)) ifa ();
    atari_slapstik_gen_if #(.ABITS(13), .BSW(3)) ifb ();

    atari_slapstik_gen dut_a (
        .CLK   (clk),
        .RST_N (rst_n),
        .bus   (ifa.slave)
    );

    atari_slapstik_gen #(
        .BANKS     (8),
        .EN_ADD    (1),
        .ADD1_MASK ('h1FF0), .ADD1_VAL ('h1600),
        .ADDI_MASK ('h1FFF), .ADDI_VAL ('h1610),
        .ADDD_MASK ('h1FFF), .ADDD_VAL ('h1611),
        .ADD3_MASK ('h1FFF), .ADD3_VAL ('h1620)
    ) dut_b (
        .CLK   (clk),
        .RST_N (rst_n),
        .bus   (ifb.slave)
    );

    int checks   = 0;
    int failures = 0;
    exp_t qa[$];
    exp_t qb[$];

    // Reference model, one slot per instance
    int banks  [2] = '{4, 8};
    int bsw    [2] = '{2, 3};
    int en_add [2] = '{0, 1};
    int m_st [2], m_bs [2], m_ta [2], m_tb [2], m_tog [2];

    int pick_tab [27] = '{'h0000, 'h0080, 'h0090, 'h00A0, 'h00B0, 'h00C0, 'h00F0,
                          'h1DFF, 'h1B5C, 'h1B5D, 'h1B5E, 'h1B5F,
                          'h1540, 'h1541, 'h1542, 'h1543, 'h1544, 'h1545, 'h1546, 'h1547,
                          'h1550, 'h1551, 'h1600, 'h1610, 'h1611, 'h1620, 'h0123};

    function automatic bit pm(input int a, input int m, input int v);
        return (a & m) == v;
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic model_reset();
        for (int c = 0; c < 2; c++) begin
            m_st[c]  = 0;
            m_bs[c]  = banks[c] - 1;
            m_ta[c]  = 0;
            m_tb[c]  = 0;
            m_tog[c] = 0;
        end
    endtask

    task automatic model_step(input int c, input int a, output int chg);
        int  nb, idx, ap, bn;
        bit  bk;
        nb  = banks[c];
        chg = 0;
        idx = (a - 'h80) >> 4;
        bk  = (a >= 'h80) && (((a - 'h80) & 'hF) == 0) && (idx < nb);
        if (a == 0) begin
            m_st[c] = 1;
        end else begin
            case (m_st[c])
                1: begin
                    if (bk) begin m_bs[c] = idx; chg = 1; m_st[c] = 0; end
                    else if (pm(a, 'h007F, 'h1FFF)) m_st[c] = 2;
                    else if (pm(a, 'h1FFF, 'h1DFF)) m_st[c] = 3;
                    else if (pm(a, 'h1FF0, 'h1540)) m_st[c] = 5;
                    else if (en_add[c] != 0 && pm(a, 'h1FF0, 'h1600)) m_st[c] = 8;
                end
                2: m_st[c] = pm(a, 'h1FFF, 'h1DFF) ? 3 : 1;
                3: begin
                    if (pm(a, 'h1FFC, 'h1B5C)) begin m_ta[c] = a % nb; m_st[c] = 4; end
                    else m_st[c] = 1;
                end
                4: if (pm(a, 'h1FCF, 'h0080)) begin m_bs[c] = m_ta[c]; chg = 1; m_st[c] = 0; end
                5: if (bk) begin m_tb[c] = m_bs[c]; m_tog[c] = 0; m_st[c] = 6; end
                6: begin
                    ap = a ^ (m_tog[c] != 0 ? 3 : 0);
                    if (pm(ap, 'h1FF0, 'h1540)) begin
                        bn = (ap >> 1) % nb;
                        if (bn < bsw[c]) begin
                            if ((ap & 1) != 0) m_tb[c] = m_tb[c] | (1 << bn);
                            else               m_tb[c] = m_tb[c] & ~(1 << bn);
                        end
                        m_tog[c] = 1 - m_tog[c];
                    end else if (pm(a, 'h1FF8, 'h1550)) begin
                        m_st[c] = 7;
                    end
                end
                7:  if (bk) begin m_bs[c] = m_tb[c]; chg = 1; m_st[c] = 0; end
                8:  if (bk) begin m_ta[c] = m_bs[c]; m_st[c] = 9; end
                9: begin
                    if (a == 'h1610)      m_ta[c] = (m_ta[c] + 1) % nb;
                    else if (a == 'h1611) m_ta[c] = (m_ta[c] + nb - 1) % nb;
                    else if (a == 'h1620) m_st[c] = 10;
                end
                10: if (bk) begin m_bs[c] = m_ta[c]; chg = 1; m_st[c] = 0; end
                default: ;
            endcase
        end
    endtask

    // One cycle: access (or idle) on instance c, the other instance idles; expectations queued for both
    task automatic cyc(input int c, input bit cs, input int a);
        exp_t e;
        int   chg;
        @(negedge clk);
        ifa.CS = (c == 0) ? cs : 1'b0;
        ifb.CS = (c == 1) ? cs : 1'b0;
        if (c == 0) ifa.AD = 13'(a); else ifb.AD = 13'(a);
        for (int k = 0; k < 2; k++) begin
            chg = 0;
            if (k == c && cs) model_step(k, a, chg);
            e.bs  = m_bs[k];
            e.chg = chg;
            e.st  = m_st[k];
            if (k == 0) qa.push_back(e); else qb.push_back(e);
        end
    endtask

    task automatic acc(input int c, input int a);
        cyc(c, 1'b1, a);
    endtask

    task automatic idle(input int c);
        cyc(c, 1'b0, int'($urandom_range(0, 'h1FFF)));
    endtask

    task automatic settle();
        @(posedge clk);
        #2;
    endtask

    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (qa.size() > 0) begin
                e = qa.pop_front();
                chk("a_bs", int'(ifa.BS), e.bs);
                chk("a_bs_chg", int'(ifa.BS_CHG), e.chg);
                chk("a_st", int'(ifa.ST), e.st);
            end
            if (qb.size() > 0) begin
                e = qb.pop_front();
                chk("b_bs", int'(ifb.BS), e.bs);
                chk("b_bs_chg", int'(ifb.BS_CHG), e.chg);
                chk("b_st", int'(ifb.ST), e.st);
            end
        end
    end

    initial begin
        int c, a;
        ifa.CS = 1'b0; ifa.AD = '0;
        ifb.CS = 1'b0; ifb.AD = '0;
        model_reset();
        #1 rst_n = 1'b0;
        #2;
        chk("rst_a_bs", int'(ifa.BS), 3);
        chk("rst_a_st", int'(ifa.ST), 0);
        chk("rst_a_chg", int'(ifa.BS_CHG), 0);
        chk("rst_b_bs", int'(ifb.BS), 7);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        // Bank address without unlock is ignored
        acc(0, 'h0090); idle(0); settle();
        chk("dis_ignore_bs", int'(ifa.BS), 3);

        // Plain bank select
        acc(0, 'h0000); acc(0, 'h00A0); settle();
        chk("bank_sel_chg", int'(ifa.BS_CHG), 1);
        chk("bank_sel_bs", int'(ifa.BS), 2);
        idle(0); settle();
        chk("bank_sel_chg_end", int'(ifa.BS_CHG), 0);
        chk("bank_sel_st", int'(ifa.ST), 0);

        // ALT sequence
        acc(0, 'h0000); acc(0, 'h1DFF); acc(0, 'h1B5D); acc(0, 'h0123); idle(0); settle();
        chk("alt_hold_st", int'(ifa.ST), 4);
        chk("alt_hold_bs", int'(ifa.BS), 2);
        acc(0, 'h0080); idle(0); settle();
        chk("alt_bs", int'(ifa.BS), 1);

        // BIT sequence from BS=2
        acc(0, 'h0000); acc(0, 'h00A0);
        acc(0, 'h0000); acc(0, 'h1540); acc(0, 'h0080); acc(0, 'h1541);
        acc(0, 'h1540); acc(0, 'h1550); idle(0); settle();
        chk("bit3_st", int'(ifa.ST), 7);
        acc(0, 'h0090); idle(0); settle();
        chk("bit_bs", int'(ifa.BS), 3);

        // ADD sequences on the 8-bank instance: 7+1 wraps to 0, then 0-1-1 = 6
        acc(1, 'h0000); acc(1, 'h1600); acc(1, 'h0080); acc(1, 'h1610);
        acc(1, 'h1620); acc(1, 'h00F0); idle(1); settle();
        chk("add_inc_bs", int'(ifb.BS), 0);
        acc(1, 'h0000); acc(1, 'h1600); acc(1, 'h0080); acc(1, 'h1611); acc(1, 'h1611);
        acc(1, 'h1620); acc(1, 'h00F0); idle(1); settle();
        chk("add_dec_bs", int'(ifb.BS), 6);

        // Asynchronous reset while in BIT2
        acc(0, 'h0000); acc(0, 'h00A0); acc(0, 'h0000); acc(0, 'h1540); acc(0, 'h0080);
        idle(0); settle();
        chk("pre_rst_st", int'(ifa.ST), 6);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_a_bs", int'(ifa.BS), 3);
        chk("mid_rst_a_st", int'(ifa.ST), 0);
        chk("mid_rst_b_bs", int'(ifb.BS), 7);
        model_reset();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        acc(0, 'h0090); idle(0); settle();
        chk("post_rst_bs", int'(ifa.BS), 3);

        // CS low for 10 cycles leaves EN untouched
        acc(0, 'h0000);
        for (int i = 0; i < 10; i++) cyc(0, 1'b0, (i % 2 == 0) ? 'h00A0 : 'h0000);
        settle();
        chk("cs_idle_st", int'(ifa.ST), 1);
        acc(0, 'h00A0); idle(0); settle();
        chk("cs_idle_then_bs", int'(ifa.BS), 2);

        // Randomised traffic on both instances
        for (int i = 0; i < 1500; i++) begin
            c = int'($urandom_range(0, 1));
            if ($urandom_range(0, 4) == 0) a = int'($urandom_range(0, 'h1FFF));
            else a = pick_tab[$urandom_range(0, 26)];
            if ($urandom_range(0, 2) == 0 && (a & 'h1FF0) == 'h1540) a = a ^ 'h8;
            cyc(c, $urandom_range(0, 9) != 0, a);
        end
        idle(0);
        settle();
        settle();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
